apb_sram_gen2: RTL and testbench

//  APB4 slave fronting an internal single-port, byte-writable synchronous SRAM.
//  It succeeds the first-generation APB SRAM and adds four things: parametrised data width,

---
 rtl/apb_sram_gen2_if.sv | 27 ++
 rtl/apb_sram_gen2.sv | 157 +++++++++++++++
 tb/tb_apb_sram_gen2.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_sram_gen2_if.sv
// APB4 bus bundle between a master and the apb_sram_gen2 slave.
interface apb_sram_gen2_if #(
  parameter int unsigned PADDR_BITS = 12,
  parameter int unsigned DATA_BITS  = 32
);
  localparam int unsigned NB = DATA_BITS / 8;

  logic [PADDR_BITS-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_BITS-1:0]  pwdata;
  logic [NB-1:0]         pstrb;
  logic                  pready;
  logic [DATA_BITS-1:0]  prdata;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_sram_gen2.sv
// APB4 slave in front of a single-port byte-writable synchronous SRAM with
// configurable wait states, byte strobes and an error response for bad addresses.
module apb_sram_gen2 #(
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rstn,
  apb_sram_gen2_if.slave apb
);
  localparam int unsigned NB       = DATA_BITS / 8;
  localparam int unsigned BOFS     = $clog2(NB);
  localparam int unsigned PA       = ADDR_BITS + BOFS;
  localparam int unsigned MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0]  WS_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [PA-1:0] OFS_MASK = PA'((64'd1 << BOFS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MEM  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e               state_q,   state_d;
  logic [3:0]           cnt_q,     cnt_d;
  logic [ADDR_BITS-1:0] idx_q,     idx_d;
  logic                 wr_q,      wr_d;
  logic [DATA_BITS-1:0] wdata_q,   wdata_d;
  logic [NB-1:0]        strb_q,    strb_d;
  logic                 err_q,     err_d;
  logic                 pready_q,  pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_BITS-1:0] prdata_q,  prdata_d;

  logic [DATA_BITS-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_BITS-1:0] word_s;
  logic                 err_s;
  logic [MEM_AW-1:0]    mem_idx_s;
  logic [DATA_BITS-1:0] rd_word_s;
  logic                 mem_we_s;

  assign word_s    = apb.paddr[PA-1:BOFS];
  assign err_s     = (32'(word_s) >= 32'(MEM_DEPTH)) ||
                     ((apb.paddr & OFS_MASK) != {PA{1'b0}});
  // Out-of-range indices only occur with err_q set, which masks both read and write.
  assign mem_idx_s = idx_q[MEM_AW-1:0];
  assign rd_word_s = mem_q[mem_idx_s];
  assign mem_we_s  = (state_q == S_MEM) && wr_q && !err_q;

  // Next-state and next-output decode for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    case (state_q)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          idx_d   = word_s;
          wr_d    = apb.pwrite;
          wdata_d = apb.pwdata;
          strb_d  = apb.pstrb;
          err_d   = err_s;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A master that drops psel here abandons the transfer without any access.
        if (!apb.psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_MEM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_MEM: begin
        state_d   = S_RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q;
        if (err_q) begin
          prdata_d = {DATA_BITS{1'b0}};
        end else if (!wr_q) begin
          prdata_d = rd_word_s;
        end else begin
          prdata_d = prdata_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, capture registers and registered bus outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= {ADDR_BITS{1'b0}};
      wr_q      <= 1'b0;
      wdata_q   <= {DATA_BITS{1'b0}};
      strb_q    <= {NB{1'b0}};
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DATA_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Byte-lane SRAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (strb_q[i]) begin
          mem_q[mem_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_sram_gen2.sv
// Scoreboard bench: two DUT instances (WS=0/depth 768 and WS=3/depth 1024) share one APB master.
module tb_apb_sram_gen2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        sel;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  apb_sram_gen2_if #(.PADDR_BITS(12), .DATA_BITS(32)) if_a ();
  apb_sram_gen2_if #(.PADDR_BITS(12), .DATA_BITS(32)) if_b ();

  apb_sram_gen2 #(.DATA_BITS(32), .ADDR_BITS(10), .MEM_DEPTH(768), .WAIT_STATES(0))
    dut_a (.clk(clk), .rstn(rstn), .apb(if_a));
  apb_sram_gen2 #(.DATA_BITS(32), .ADDR_BITS(10), .MEM_DEPTH(1024), .WAIT_STATES(3))
    dut_b (.clk(clk), .rstn(rstn), .apb(if_b));

  assign if_a.paddr   = paddr;   assign if_b.paddr   = paddr;
  assign if_a.penable = penable; assign if_b.penable = penable;
  assign if_a.pwrite  = pwrite;  assign if_b.pwrite  = pwrite;
  assign if_a.pwdata  = pwdata;  assign if_b.pwdata  = pwdata;
  assign if_a.pstrb   = pstrb;   assign if_b.pstrb   = pstrb;
  assign if_a.psel    = psel & ~sel;
  assign if_b.psel    = psel & sel;

  logic        pready_m, pslverr_m, pready_o;
  logic [31:0] prdata_m;
  assign pready_m  = sel ? if_b.pready  : if_a.pready;
  assign pslverr_m = sel ? if_b.pslverr : if_a.pslverr;
  assign prdata_m  = sel ? if_b.prdata  : if_a.prdata;
  assign pready_o  = sel ? if_a.pready  : if_b.pready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [31:0] mdl_rd(input int w);
    if (sel) return mdl_b.exists(w) ? mdl_b[w] : 32'd0;
    else     return mdl_a.exists(w) ? mdl_a[w] : 32'd0;
  endfunction

  task automatic mdl_wr(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mdl_rd(w);
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    if (sel) mdl_b[w] = v;
    else     mdl_a[w] = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  // One complete APB transfer; expectation is pushed at setup, latency checked here.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    exp_t x;
    int   w, depth, ws, cyc;
    bit   done;
    w     = int'(addr[11:2]);
    depth = sel ? 1024 : 768;
    ws    = sel ? 3 : 0;
    x.is_rd = ~wr;
    x.err   = (w >= depth) || (addr[1:0] != 2'b00);
    x.data  = 32'd0;
    if (!x.err) begin
      if (wr) mdl_wr(w, data, strb);
      else    x.data = mdl_rd(w);
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    sb_q.push_back(x);
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pready_m) begin
        done = 1'b1;
      end else if (cyc >= 40) begin
        chk("pready_timeout", 32'(cyc), 32'(2 + ws));
        finish_run();
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("latency", 32'(cyc), 32'(2 + ws));
  endtask

  // Monitor: pops the scoreboard whenever the selected slave completes a transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn) begin
      if (pready_m) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pready", 32'(pready_m), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("pslverr", 32'(pslverr_m), 32'(e.err));
          if (e.is_rd) chk("prdata", prdata_m, e.data);
        end
      end else if (pslverr_m) begin
        chk("pslverr_idle", 32'(pslverr_m), 32'd0);
      end
      if (pready_o) chk("pready_unselected", 32'(pready_o), 32'd0);
    end
  end

  task automatic random_ops(input int n);
    logic [11:0] a;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      a = {10'($urandom_range(0, 15)), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = {10'($urandom_range(768, 1023)), 2'b00};
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  task automatic prefill();
    for (int w = 0; w < 16; w++) xfer(1'b1, {10'(w), 2'b00}, $urandom, 4'hF);
  endtask

  initial begin
    rstn = 1'b0; sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'h0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready_a",  32'(if_a.pready),  32'd0);
    chk("rst_pslverr_a", 32'(if_a.pslverr), 32'd0);
    chk("rst_prdata_a",  if_a.prdata,       32'd0);
    chk("rst_pready_b",  32'(if_b.pready),  32'd0);
    chk("rst_pslverr_b", 32'(if_b.pslverr), 32'd0);
    chk("rst_prdata_b",  if_b.prdata,       32'd0);
    rstn = 1'b1;
    idle(2);

    // Instance A: no wait states, 768 words.
    prefill();
    xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 12'h004, 32'h0, 4'h0);
    xfer(1'b1, 12'h004, 32'h000000AA, 4'h1);
    xfer(1'b0, 12'h004, 32'h0, 4'h0);
    xfer(1'b1, 12'h004, 32'hFFFFFFFF, 4'h0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0);
    xfer(1'b0, 12'hC00, 32'h0, 4'h0);
    xfer(1'b1, 12'hC00, 32'h55AA55AA, 4'hF);
    xfer(1'b0, 12'h000, 32'h0, 4'h0);
    xfer(1'b1, 12'h006, 32'h12345678, 4'hF);
    xfer(1'b0, 12'h006, 32'h0, 4'h0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0);
    // Access phase without a preceding setup must be ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hFFFF0000; pstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_setup_pready", 32'(pready_m), 32'd0);
    end
    idle(2);
    xfer(1'b0, 12'h008, 32'h0, 4'h0);
    random_ops(60);
    idle(2);

    // Instance B: three wait states, 1024 words.
    sel = 1'b1;
    idle(1);
    prefill();
    xfer(1'b1, 12'h014, 32'hA5A5C3C3, 4'hF);
    xfer(1'b0, 12'h014, 32'h0, 4'h0);
    xfer(1'b0, 12'hC00, 32'h0, 4'h0);
    xfer(1'b1, 12'h010, 32'h12345678, 4'hF);
    xfer(1'b0, 12'h014, 32'h0, 4'h0);
    // Reset while a write sits in WAIT: outputs clear and the write is lost.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #2;
    chk("midrst_pready",  32'(pready_m),  32'd0);
    chk("midrst_pslverr", 32'(pslverr_m), 32'd0);
    chk("midrst_prdata",  prdata_m,       32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    xfer(1'b0, 12'h010, 32'h0, 4'h0);
    // Master drops psel during WAIT: no write, no response.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_pready", 32'(pready_m), 32'd0);
    end
    xfer(1'b0, 12'h014, 32'h0, 4'h0);
    random_ops(40);
    idle(4);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    finish_run();
  end
endmodule
